// File: rtl/stream_extreme_pkg.sv
// Shared definitions for the stream extreme finder.
// Contents:
//   state_t        - controller state encoding (2 bits)
//   MODE_UNSIGNED  - compare mode value for unsigned samples
//   MODE_SIGNED    - compare mode value for two's-complement samples
package stream_extreme_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/stream_extreme_finder_cmp_gt.sv
// Combinational greater-than comparator, signed or unsigned.
// Ports:
//   a, b  in  WIDTH  operands
//   mode  in  1      MODE_SIGNED = two's complement, MODE_UNSIGNED = unsigned
//   agtb  out 1      1 when a > b under the selected interpretation
module cmp_gt
  import stream_extreme_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             agtb
);

  localparam int MSB = WIDTH - 1;

  // When the sign bits differ the answer depends only on the mode: an MSB of 1
  // is the larger value when unsigned and the smaller one when signed. With
  // equal MSBs both interpretations reduce to an unsigned compare of the rest.
  always_comb begin
    if (a[MSB] != b[MSB]) begin
      agtb = (mode == MODE_SIGNED) ? ~a[MSB] : a[MSB];
    end else begin
      agtb = (a[MSB-1:0] > b[MSB-1:0]);
    end
  end

endmodule

// File: rtl/stream_extreme_finder.sv
// Finds the maximum or minimum sample of a burst on a valid/ready stream,
// using one shared comparator at one sample per clock.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   start, len, mode,       burst request; len/mode/find_min are captured
//   find_min                when start is accepted in IDLE
//   s_data, s_valid,        sample stream; a beat moves on s_valid & s_ready
//   s_ready
//   busy                    high from the cycle after start until done, inclusive
//   done, zero_len          one-cycle completion pulse; zero_len marks len==0
//   result, result_idx      extreme value and its 0-based index in the burst
module stream_extreme_finder
  import stream_extreme_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  input  logic             find_min,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             zero_len,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] result_idx
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] len_reg;
  logic             mode_reg;
  logic             find_min_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] best_reg, best_next;
  logic [CNT_W-1:0] best_idx_reg, best_idx_next;
  logic [WIDTH-1:0] result_reg;
  logic [CNT_W-1:0] result_idx_reg;
  logic             busy_reg, done_reg, zero_len_reg;

  logic             hs;
  logic             last_beat;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             replace;

  assign s_ready    = (state_reg == ST_FIRST) || (state_reg == ST_SCAN);
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign zero_len   = zero_len_reg;
  assign result     = result_reg;
  assign result_idx = result_idx_reg;

  assign hs        = s_valid && s_ready;
  assign last_beat = (cnt_reg == len_reg - CNT_W'(1));

  // Searching for a minimum is a max search with the operands swapped, so a
  // single comparator serves both targets.
  assign cmp_a = find_min_reg ? best_reg : s_data;
  assign cmp_b = find_min_reg ? s_data   : best_reg;

  cmp_gt #(.WIDTH(WIDTH)) u_cmp (
    .a    (cmp_a),
    .b    (cmp_b),
    .mode (mode_reg),
    .agtb (replace)
  );

  always_comb begin
    state_next    = state_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? ST_DONE : ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (hs) begin
          best_next     = s_data;
          best_idx_next = '0;
          state_next    = (len_reg == CNT_W'(1)) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hs) begin
          // Strict compare: on a tie the earlier index is kept.
          if (replace) begin
            best_next     = s_data;
            best_idx_next = cnt_reg;
          end
          if (last_beat) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      mode_reg       <= MODE_UNSIGNED;
      find_min_reg   <= 1'b0;
      cnt_reg        <= '0;
      best_reg       <= '0;
      best_idx_reg   <= '0;
      result_reg     <= '0;
      result_idx_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      zero_len_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
      busy_reg     <= (state_next != ST_IDLE);
      done_reg     <= (state_next == ST_DONE);
      zero_len_reg <= (state_reg == ST_IDLE) && start && (len == '0);

      if (state_reg == ST_IDLE && start) begin
        len_reg        <= len;
        mode_reg       <= mode;
        find_min_reg   <= find_min;
        cnt_reg        <= '0;
        result_reg     <= '0;
        result_idx_reg <= '0;
      end

      if (hs) begin
        cnt_reg <= (state_reg == ST_FIRST) ? CNT_W'(1) : cnt_reg + CNT_W'(1);
      end

      // Publish only when the burst actually scanned samples; a zero-length
      // burst keeps the cleared result.
      if (s_ready && state_next == ST_DONE) begin
        result_reg     <= best_next;
        result_idx_reg <= best_idx_next;
      end
    end
  end

endmodule
